acc_register: RTL and testbench
===============================

// Module: acc_register
// PURPOSE
//   Accumulator register of the single-cycle CPU datapath. Holds the working
//   operand/result word between instructions.
//   Loads the ALU result on IN when CE is asserted and holds it otherwise.
//   OUT feeds the ALU operand mux and the data-memory write path.
// PARAMETERS
//   WIDTH      4   data word width in bits (>=1)
//   RESET_VAL  0   value loaded into the register on reset (WIDTH bits)
// PORTS
//   CLK    in   1      system clock, rising-edge active
//   RST_N  in   1      asynchronous reset, active-low
//   CE     in   1      clock enable / load strobe
//   IN     in   WIDTH  data to load
//   OUT    out  WIDTH  registered accumulator contents
//   ZERO   out  1      1 when OUT == 0 (combinational from register)
// BEHAVIOUR
//   - Clocking and reset:
//     - One clock domain (CLK).
//     - Reset is asynchronous and active-low (RST_N).
//     - RST_N=0 forces OUT=RESET_VAL immediately, independent of CLK and CE.
//     - RST_N=0 also drives ZERO=(RESET_VAL==0), i.e. ZERO=1 with the default.
//     - Release of RST_N is sampled synchronously; the first load can occur at
//       the first rising CLK edge after RST_N=1.
//   - Load and hold:
//     - Rising CLK edge with RST_N=1 and CE=1: OUT <= IN. This is a plain load;
//       no addition is performed.
//     - Rising CLK edge with CE=0: OUT holds its value.
//     - Load latency is one clock: OUT reflects IN after the sampling edge and
//       is stable for the whole following cycle.
//     - IN and CE changes between edges have no effect on OUT.
//   - CE held high: back-to-back loads occur on every edge; each edge takes the
//     IN value present at that edge.
//   - Widths: IN is loaded verbatim at full WIDTH, with no truncation,
//     extension or sign handling.
//   - ZERO: combinational NOR of OUT, so it updates with OUT.
//   - Unknown inputs: an X on CE or IN at an edge may propagate to OUT;
//     no X-masking is required.
//   - Reset during a load edge: reset wins and OUT=RESET_VAL.
//   - No internal state other than the WIDTH-bit register.
// TESTING
//   1) RST_N=0 with CE=1, IN=4'b1010, clock running -> OUT=4'b0000, ZERO=1
//      throughout reset.
//   2) RST_N=1, CE=0, IN=4'b0101 for one edge -> OUT stays 4'b0000.
//      Then CE=1 for one edge -> OUT=4'b0101 after that edge, ZERO=0.
//   3) CE=0, IN=4'b1111 for three edges -> OUT remains 4'b0101.
//   4) CE=1, IN=4'b1111 then 4'b0000 on consecutive edges ->
//      OUT=4'b1111 then 4'b0000, ZERO=1.
//      Hold CE=0 for 10 edges -> OUT stays 4'b0000.
//   5) Load 4'b1001. Assert RST_N=0 mid-cycle, away from any edge ->
//      OUT=4'b0000 before the next edge.
//      Release RST_N, then CE=1 with IN=4'b0011 -> OUT=4'b0011.
//   6) WIDTH=8, RESET_VAL=8'hA5: reset -> OUT=8'hA5, ZERO=0.
//      Load IN=8'hFF -> OUT=8'hFF.

Source files
------------

// File: rtl/acc_register.sv
// -----------------------------------------------------------------------------
// acc_register
//   Accumulator register of the single-cycle CPU datapath. It holds the working
//   operand/result word between instructions. It loads the ALU result from IN
//   on a rising CLK edge when CE is high, and holds its value otherwise.
//
// Parameters
//   WIDTH      data word width in bits (>= 1)
//   RESET_VAL  value forced into the register while RST_N is low
//
// Ports
//   CLK    in   1      system clock, rising-edge active
//   RST_N  in   1      asynchronous reset, active-low
//   CE     in   1      clock enable / load strobe
//   IN     in   WIDTH  data to load (taken verbatim, no arithmetic)
//   OUT    out  WIDTH  registered accumulator contents
//   ZERO   out  1      high when OUT == 0, decoded combinationally from OUT
// -----------------------------------------------------------------------------
module acc_register #(
    parameter int unsigned           WIDTH     = 4,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic [WIDTH-1:0] IN,
    output logic [WIDTH-1:0] OUT,
    output logic             ZERO
);

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;

    // Plain load when enabled, otherwise recirculate the held value.
    always_comb begin
        acc_next = acc_reg;
        if (CE) begin
            acc_next = IN;
        end
    end

    // Reset takes effect immediately and overrides any load on the same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_reg <= RESET_VAL;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign OUT  = acc_reg;
    // Decoded from the register itself so it tracks OUT, including during reset.
    assign ZERO = ~|acc_reg;

endmodule

// File: tb/tb_acc_register.sv
// -----------------------------------------------------------------------------
// tb_acc_register
//   Directed testbench for acc_register. Two instances are exercised: the
//   default 4-bit / reset-to-zero build and an 8-bit build resetting to 8'hA5.
// -----------------------------------------------------------------------------
module tb_acc_register;

    logic       clk;
    logic       rst_n4, ce4;
    logic [3:0] in4, out4;
    logic       zero4;
    logic       rst_n8, ce8;
    logic [7:0] in8, out8;
    logic       zero8;

    int passed = 0;
    int total  = 0;

    acc_register #(.WIDTH(4)) dut4 (
        .CLK   (clk),
        .RST_N (rst_n4),
        .CE    (ce4),
        .IN    (in4),
        .OUT   (out4),
        .ZERO  (zero4)
    );

    acc_register #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .CLK   (clk),
        .RST_N (rst_n8),
        .CE    (ce8),
        .IN    (in8),
        .OUT   (out8),
        .ZERO  (zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle 2 time units past it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n4 = 1'b0; ce4 = 1'b1; in4 = 4'b1010;
        rst_n8 = 1'b0; ce8 = 1'b1; in8 = 8'h3C;
        #2;

        // 1) Reset held with CE=1 and clock running: loads are suppressed.
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_out_%0d", i), {4'b0, out4}, 8'h00);
            check($sformatf("rst_zero_%0d", i), {7'b0, zero4}, 8'h01);
            tick();
        end
        check("rst8_out", out8, 8'hA5);
        check("rst8_zero", {7'b0, zero8}, 8'h00);

        // 2) Release, CE=0 for one edge: hold; then CE=1 loads.
        rst_n4 = 1'b1; ce4 = 1'b0; in4 = 4'b0101;
        tick();
        check("hold_after_rel", {4'b0, out4}, 8'h00);
        ce4 = 1'b1;
        tick();
        check("load_0101", {4'b0, out4}, 8'h05);
        check("load_0101_zero", {7'b0, zero4}, 8'h00);

        // 3) CE=0 with new IN for three edges: value held.
        ce4 = 1'b0; in4 = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_0101_%0d", i), {4'b0, out4}, 8'h05);
        end

        // Mid-cycle IN/CE wiggle between edges has no effect.
        #2 ce4 = 1'b1; in4 = 4'b0110;
        #1 ce4 = 1'b0; in4 = 4'b1111;
        check("midcycle_no_effect", {4'b0, out4}, 8'h05);

        // 4) Back-to-back loads, then long hold.
        ce4 = 1'b1; in4 = 4'b1111;
        tick();
        check("b2b_1111", {4'b0, out4}, 8'h0F);
        check("b2b_1111_zero", {7'b0, zero4}, 8'h00);
        in4 = 4'b0000;
        tick();
        check("b2b_0000", {4'b0, out4}, 8'h00);
        check("b2b_0000_zero", {7'b0, zero4}, 8'h01);
        ce4 = 1'b0; in4 = 4'b1011;
        for (int i = 0; i < 10; i++) tick();
        check("hold10_0000", {4'b0, out4}, 8'h00);

        // 5) Load 1001, then asynchronous reset mid-cycle.
        ce4 = 1'b1; in4 = 4'b1001;
        tick();
        check("load_1001", {4'b0, out4}, 8'h09);
        ce4 = 1'b0;
        #1 rst_n4 = 1'b0;
        #1;
        check("async_rst_out", {4'b0, out4}, 8'h00);
        check("async_rst_zero", {7'b0, zero4}, 8'h01);
        @(negedge clk);
        rst_n4 = 1'b1; ce4 = 1'b1; in4 = 4'b0011;
        tick();
        check("load_0011", {4'b0, out4}, 8'h03);

        // 6) 8-bit instance: release and load FF, then async reset to A5.
        rst_n8 = 1'b1; ce8 = 1'b1; in8 = 8'hFF;
        tick();
        check("w8_load_ff", out8, 8'hFF);
        check("w8_load_ff_zero", {7'b0, zero8}, 8'h00);
        ce8 = 1'b1; in8 = 8'h00;
        tick();
        check("w8_load_00_zero", {7'b0, zero8}, 8'h01);
        #1 rst_n8 = 1'b0;
        #1;
        check("w8_async_rst", out8, 8'hA5);
        check("w8_async_rst_zero", {7'b0, zero8}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
